// File: rtl/instr_sequencer.sv
// Instruction fetch/issue sequencer: walks a synchronous instruction memory and
// issues one {opcode, operand} per instruction for a single cycle, stalling on READOUT.
module instr_sequencer #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned OPND_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_W-1:0]     imem_addr,
    input  logic [4+OPND_W-1:0]   imem_rdata,
    output logic [3:0]            opcode,
    output logic [OPND_W-1:0]     operand,
    output logic                  issue_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     pc
);

    localparam int unsigned OP_W  = 4;
    localparam int unsigned INS_W = OP_W + OPND_W;

    localparam logic [OP_W-1:0] OP_NOP     = 4'b0000;
    localparam logic [OP_W-1:0] OP_READOUT = 4'b0011;
    localparam logic [OP_W-1:0] OP_RSVD    = 4'b1110;
    localparam logic [OP_W-1:0] OP_HALT    = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_ISSUE   = 3'd3,
        S_RD_WAIT = 3'd4
    } state_t;

    state_t               r_state;
    logic [OP_W-1:0]      r_instr_op;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    r_imem_addr;
    logic [OP_W-1:0]      r_opcode;
    logic [OPND_W-1:0]    r_operand;
    logic                 r_issue_valid;
    logic                 r_busy;
    logic                 r_done;

    logic [OP_W-1:0]      w_rd_op;
    logic [OPND_W-1:0]    w_rd_opnd;
    logic                 w_rd_is_nop;
    logic [ADDR_W-1:0]    w_pc_inc;

    assign w_rd_op     = imem_rdata[INS_W-1 -: OP_W];
    assign w_rd_opnd   = imem_rdata[OPND_W-1:0];
    assign w_rd_is_nop = (w_rd_op == OP_NOP) || (w_rd_op == OP_RSVD);
    assign w_pc_inc    = r_pc + ADDR_W'(1);

    // imem_addr is loaded on entry to FETCH so the synchronous memory's word
    // is available during DECODE; issue outputs are loaded on entry to ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_instr_op    <= '0;
            r_pc          <= '0;
            r_imem_addr   <= '0;
            r_opcode      <= '0;
            r_operand     <= '0;
            r_issue_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_opcode      <= '0;
            r_operand     <= '0;
            r_issue_valid <= 1'b0;
            r_done        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_FETCH;
                        r_pc        <= '0;
                        r_imem_addr <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_instr_op <= w_rd_op;
                    if (w_rd_op == OP_HALT) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state       <= S_ISSUE;
                        r_opcode      <= w_rd_is_nop ? OP_NOP : w_rd_op;
                        r_operand     <= w_rd_opnd;
                        r_issue_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (r_instr_op == OP_READOUT) begin
                        r_state <= S_RD_WAIT;
                    end else begin
                        r_state     <= S_FETCH;
                        r_pc        <= w_pc_inc;
                        r_imem_addr <= w_pc_inc;
                    end
                end
                S_RD_WAIT: begin
                    if (out_ready) begin
                        r_state     <= S_FETCH;
                        r_pc        <= w_pc_inc;
                        r_imem_addr <= w_pc_inc;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr   = r_imem_addr;
    assign opcode      = r_opcode;
    assign operand     = r_operand;
    assign issue_valid = r_issue_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pc          = r_pc;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed and random programs checked cycle by cycle
// against a schedule derived from the instruction timing rules.
module tb_instr_sequencer;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned OPND_W = 4;
    localparam int          MAXC   = 256;
    localparam int          MSIZE  = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                out_ready;
    logic [ADDR_W-1:0]   imem_addr;
    logic [7:0]          imem_rdata;
    logic [3:0]          opcode;
    logic [OPND_W-1:0]   operand;
    logic                issue_valid;
    logic                busy;
    logic                done;
    logic [ADDR_W-1:0]   pc;

    logic [7:0] mem [MSIZE];
    bit         rdy [MAXC];
    int         e_iv [MAXC];
    int         e_op [MAXC];
    int         e_opnd [MAXC];
    int         e_busy [MAXC];
    int         e_done [MAXC];
    int         e_pc [MAXC];
    int         n_cyc;
    int         total = 0;
    int         bad   = 0;

    instr_sequencer #(.ADDR_W(ADDR_W), .OPND_W(OPND_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .opcode      (opcode),
        .operand     (operand),
        .issue_valid (issue_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= mem[imem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mark(input int c, input int b, input int p);
        if (c < n_cyc) begin
            e_busy[c] = b;
            e_pc[c]   = p;
        end
    endtask

    // Schedule: instruction at fetch cycle f decodes at f+1, issues at f+2;
    // READOUT waits from f+3 until the first cycle with out_ready; HALT pulses done at f+2.
    task automatic build_model();
        int f;
        int a;
        int op;
        int c;
        f = 1;
        a = 0;
        for (int i = 0; i < MAXC; i++) begin
            e_iv[i] = 0; e_op[i] = 0; e_opnd[i] = 0;
            e_busy[i] = 0; e_done[i] = 0; e_pc[i] = 0;
        end
        while (f < n_cyc) begin
            op = int'(mem[a][7:4]);
            mark(f, 1, a);
            mark(f + 1, 1, a);
            if (op == 15) begin
                if (f + 2 < n_cyc) e_done[f + 2] = 1;
                for (int k = f + 2; k < n_cyc; k++) mark(k, 0, a);
                break;
            end
            mark(f + 2, 1, a);
            if (f + 2 < n_cyc) begin
                e_iv[f + 2]   = 1;
                e_op[f + 2]   = (op == 0 || op == 14) ? 0 : op;
                e_opnd[f + 2] = int'(mem[a][3:0]);
            end
            if (op == 3) begin
                c = f + 3;
                while (c < n_cyc && !rdy[c]) begin
                    mark(c, 1, a);
                    c++;
                end
                mark(c, 1, a);
                f = c + 1;
            end else begin
                f = f + 3;
            end
            a = (a + 1) % MSIZE;
        end
    endtask

    task automatic run_prog(input string name);
        build_model();
        @(negedge clk);
        start     = 1'b1;
        out_ready = rdy[0];
        for (int c = 1; c < n_cyc; c++) begin
            @(negedge clk);
            chk($sformatf("%s c%0d issue_valid", name, c), 32'(issue_valid), 32'(e_iv[c]));
            chk($sformatf("%s c%0d opcode", name, c), 32'(opcode), 32'(e_op[c]));
            chk($sformatf("%s c%0d operand", name, c), 32'(operand), 32'(e_opnd[c]));
            chk($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(e_busy[c]));
            chk($sformatf("%s c%0d done", name, c), 32'(done), 32'(e_done[c]));
            chk($sformatf("%s c%0d pc", name, c), 32'(pc), 32'(e_pc[c]));
            start     = (e_busy[c] != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready = rdy[c];
        end
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < MSIZE; i++) mem[i] = 8'h00;
        for (int i = 0; i < MAXC; i++) rdy[i] = 1'b1;
    endtask

    task automatic check_idle(input string name);
        chk({name, " issue_valid"}, 32'(issue_valid), 32'd0);
        chk({name, " opcode"}, 32'(opcode), 32'd0);
        chk({name, " operand"}, 32'(operand), 32'd0);
        chk({name, " busy"}, 32'(busy), 32'd0);
        chk({name, " done"}, 32'(done), 32'd0);
        chk({name, " pc"}, 32'(pc), 32'd0);
    endtask

    initial begin
        int op;
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        clear_prog();
        repeat (2) @(negedge clk);
        check_idle("reset");
        chk("reset imem_addr", 32'(imem_addr), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_idle($sformatf("idle c%0d", i));
        end

        // basic program
        clear_prog();
        mem[0] = 8'h13; mem[1] = 8'h25; mem[2] = 8'h40; mem[3] = 8'hF0;
        n_cyc = 16;
        run_prog("basic");

        // READOUT stall: out_ready low for 5 RD_WAIT cycles
        clear_prog();
        mem[0] = 8'h30; mem[1] = 8'hF0;
        for (int i = 0; i < 9; i++) rdy[i] = 1'b0;
        n_cyc = 18;
        run_prog("readout");

        // reserved and NOP both issue opcode 0
        clear_prog();
        mem[0] = 8'hE7; mem[1] = 8'h05; mem[2] = 8'hF0;
        n_cyc = 14;
        run_prog("nop");

        // full-memory program without HALT: pc wraps to 0
        clear_prog();
        for (int i = 0; i < MSIZE; i++) begin
            op = int'($urandom_range(0, 13));
            if (op == 3) op = 14;
            mem[i] = {4'(op), 4'($urandom_range(0, 15))};
        end
        n_cyc = 62;
        run_prog("wrap");
        do_reset();

        // random programs with random READOUT back-pressure
        for (int t = 0; t < 4; t++) begin
            clear_prog();
            for (int i = 0; i < MSIZE; i++) begin
                op = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 14));
                mem[i] = {4'(op), 4'($urandom_range(0, 15))};
            end
            for (int i = 0; i < MAXC; i++) rdy[i] = ($urandom_range(0, 2) == 0);
            n_cyc = 120;
            run_prog($sformatf("rand%0d", t));
            do_reset();
        end

        // reset asserted during the LOADB issue cycle
        clear_prog();
        mem[0] = 8'h13; mem[1] = 8'h25; mem[2] = 8'h40; mem[3] = 8'hF0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst pre issue_valid", 32'(issue_valid), 32'd1);
        chk("midrst pre opcode", 32'(opcode), 32'd2);
        rst_n = 1'b0;
        #1;
        check_idle("midrst async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_idle($sformatf("midrst post c%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Instruction fetch/issue sequencer; produces the 4-bit opcode stream consumed by the core CPU controller decoder.
Reads instruction words from a synchronous instruction memory and presents one opcode plus operand per instruction for exactly one issue cycle.
Stalls on READOUT until the output sink acknowledges.
Stops on HALT.

Parameters:
ADDR_W, 4, instruction memory address / program counter width
OPND_W, 4, operand field width; instruction word is {opcode[3:0], operand[OPND_W-1:0]}

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin execution from address 0; sampled only in IDLE
imem_addr  output  ADDR_W  instruction memory address
imem_rdata  input  4+OPND_W  instruction word, valid the cycle after imem_addr is presented
opcode  output  4  opcode to controller; 4'b0000 outside issue cycles
operand  output  OPND_W  operand accompanying opcode; 0 outside issue cycles
issue_valid  output  1  high for exactly one cycle per issued instruction
out_ready  input  1  sink acknowledge for READOUT
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse when HALT is decoded
pc  output  ADDR_W  current program counter

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; pc=0; imem_addr=0; opcode=0; operand=0; instr register=0.
  - issue_valid, busy, done all 0.
  - Release takes effect on the next rising edge.
- Opcode map:
  - 0000 NOP.
  - 0001 LOADA, 0010 LOADB.
  - 0011 READOUT.
  - 0100–1101 ALU ops (load C).
  - 1110 reserved, executed as NOP.
  - 1111 HALT.
- States: IDLE, FETCH, DECODE, ISSUE, RD_WAIT.
- IDLE:
  - start=1 -> FETCH, with pc=0.
  - Otherwise stay in IDLE.
  - start is ignored in all other states.
- FETCH:
  - imem_addr=pc.
  - Next state DECODE.
- DECODE:
  - Register imem_rdata into instr.
  - instr opcode 1111 -> done=1 next cycle, state=IDLE, pc unchanged (keeps HALT address); nothing is issued.
  - Otherwise -> ISSUE.
- ISSUE (one cycle):
  - opcode=instr[opcode field], operand=instr[operand field], issue_valid=1.
  - NOP/reserved: opcode driven as 0000, issue_valid still 1.
  - READOUT -> RD_WAIT.
  - All others -> FETCH with pc=pc+1.
- RD_WAIT:
  - opcode=0000, issue_valid=0; the READOUT opcode is presented only during ISSUE, so the controller's read_en pulses once.
  - out_ready=1 -> FETCH with pc=pc+1.
  - out_ready already high in ISSUE does not skip RD_WAIT; minimum stay is 1 cycle.
- Throughput: 3 cycles per non-READOUT instruction (FETCH, DECODE, ISSUE). READOUT takes 3 + N cycles, where N ≥ 1 is the number of RD_WAIT cycles.
- pc wrap-around: pc = 2^ADDR_W-1 increments to 0 and execution continues (modulo arithmetic, no flag).
- Outputs are registered; opcode/operand/issue_valid change only on clock edges.
- busy=1 from the cycle after start is accepted until the cycle IDLE is re-entered.
- done and busy: done asserts in the first IDLE cycle after HALT, so done and busy are never both high.
- Reset mid-operation (any state) returns all outputs to reset values immediately; no partial issue completes.

Test Plan:
- Reset/idle: rst_n low then high, start=0 for 10 cycles -> opcode=0, issue_valid=0, busy=0, pc=0 throughout.
- Basic program:
  - Memory: [0]=0x13 LOADA 3, [1]=0x25 LOADB 5, [2]=0x40 ALU, [3]=0xF0 HALT; pulse start.
  - Response: issue_valid pulses at cycles 3, 6, 9 after start with opcode 1, 2, 4 and operand 3, 5, 0.
  - Then done pulses once and busy falls; pc=3.
- READOUT stall: [0]=0x30, [1]=0xF0; out_ready held 0 for 5 cycles then 1 -> opcode=0011 for exactly one cycle; pc stays 0 during the stall; HALT follows; done pulses.
- Reserved/NOP: [0]=0xE7, [1]=0x05, [2]=0xF0 -> two issue_valid pulses, both with opcode=0000; no nonzero opcode ever appears.
- Wrap-around: ADDR_W=2, [0..3]=0x10, start -> opcode 0001 issued at pc 0, 1, 2, 3, 0, 1…; pc rolls from 3 to 0; busy stays 1.
- Reset mid-run: assert rst_n low during ISSUE of LOADB -> opcode and issue_valid drop to 0 asynchronously (same cycle); after release, state=IDLE, pc=0, no spurious done.
